// File: rtl/usb_pkg.sv
// Shared definitions for the USB TX path: header layout, magic byte and the
// packet-framing FSM state type.
package usb_pkg;

  // Header word layout: {magic, source, seq, 7'b0, cont}
  localparam logic [7:0]  HdrMagic    = 8'hA5;
  localparam int unsigned HdrMagicLsb = 24;
  localparam int unsigned HdrSrcLsb   = 16;
  localparam int unsigned HdrSeqLsb   = 8;
  localparam int unsigned HdrContBit  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload
  } tx_state_e;

  // Assemble a packet header word from its fields.
  function automatic logic [31:0] build_header(input logic [7:0] src,
                                               input logic [7:0] seq,
                                               input logic       cont);
    logic [31:0] hdr;
    hdr                   = '0;
    hdr[HdrMagicLsb +: 8] = HdrMagic;
    hdr[HdrSrcLsb +: 8]   = src;
    hdr[HdrSeqLsb +: 8]   = seq;
    hdr[HdrContBit]       = cont;
    return hdr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from
// last_grant_i + 1 with wrap-around.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_grant_i,
  output logic [IdxW-1:0]   grant_o,
  output logic              any_req_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_o   = last_grant_i;
    any_req_o = |req_i;
    sum       = '0;
    cand      = '0;
    for (int off = int'(NumReq); off > 0; off--) begin
      sum = {1'b0, last_grant_i} + (IdxW + 1)'(off);
      if (sum >= (IdxW + 1)'(NumReq)) begin
        sum = sum - (IdxW + 1)'(NumReq);
      end
      cand = sum[IdxW-1:0];
      if (req_i[cand]) begin
        grant_o = cand;
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Multiplexes packetised TX words from several peripherals into a single
// word stream for the FT601 controller. Each packet is framed by a header
// word; long packets are split at MAX_PKT_WORDS with a continuation flag.
module usb_tx_arbiter
  import usb_pkg::*;
#(
  parameter int unsigned NUM_PERIPH    = 4,
  parameter int unsigned MAX_PKT_WORDS = 256
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [NUM_PERIPH-1:0]      periph_valid,
  input  logic [NUM_PERIPH*32-1:0]   periph_data,
  input  logic [NUM_PERIPH*4-1:0]    periph_be,
  input  logic [NUM_PERIPH-1:0]      periph_last,
  output logic [NUM_PERIPH-1:0]      periph_ready,
  output logic [31:0]                data_i,
  output logic [3:0]                 i_valid,
  output logic                       periph_data_available,
  input  logic                       read_periph_data
);

  localparam int unsigned IdxW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam int unsigned CntW = $clog2(MAX_PKT_WORDS + 1);

  tx_state_e             state_q;
  logic [IdxW-1:0]       grant_q;
  logic [IdxW-1:0]       last_grant_q;
  logic [7:0]            seq_q;
  logic [NUM_PERIPH-1:0] cont_q;
  logic [CntW-1:0]       wcnt_q;
  logic                  full_q;
  logic [31:0]           data_q;
  logic [3:0]            be_q;

  logic [IdxW-1:0]       arb_grant;
  logic                  arb_any;
  logic                  load_ok;
  logic                  cur_valid;
  logic                  cur_last;
  logic [31:0]           cur_data;
  logic [3:0]            cur_be;
  logic                  accept;
  logic                  pkt_end;
  logic [31:0]           hdr_word;

  rr_arbiter #(
    .NumReq (NUM_PERIPH),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i        (periph_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .any_req_o    (arb_any)
  );

  // Output register may take a new word when empty or being drained this cycle.
  assign load_ok = !full_q || read_periph_data;

  // Select the granted source's word, enables and flags.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    cur_be    = '0;
    for (int i = 0; i < int'(NUM_PERIPH); i++) begin
      if (grant_q == IdxW'(i)) begin
        cur_valid = periph_valid[i];
        cur_last  = periph_last[i];
        cur_data  = periph_data[i*32 +: 32];
        cur_be    = periph_be[i*4 +: 4];
      end
    end
  end

  // Only the granted source sees ready, and only while streaming payload.
  always_comb begin
    periph_ready = '0;
    if (state_q == StPayload && load_ok) begin
      periph_ready[grant_q] = 1'b1;
    end
  end

  assign accept   = (state_q == StPayload) && load_ok && cur_valid;
  // A last marker coinciding with the size limit is a normal end.
  assign pkt_end  = accept && (cur_last || (wcnt_q == CntW'(MAX_PKT_WORDS - 1)));
  assign hdr_word = build_header(8'(grant_q), seq_q, cont_q[grant_q]);

  // Packet framing FSM together with the single-entry output register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IdxW'(NUM_PERIPH - 1);
      seq_q        <= '0;
      cont_q       <= '0;
      wcnt_q       <= '0;
      full_q       <= 1'b0;
      data_q       <= '0;
      be_q         <= '0;
    end else begin
      // Drain first; a load below in the same cycle refills the register.
      if (full_q && read_periph_data) begin
        full_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            state_q <= StHeader;
          end
        end
        StHeader: begin
          if (load_ok) begin
            data_q  <= hdr_word;
            be_q    <= 4'b1111;
            full_q  <= 1'b1;
            state_q <= StPayload;
          end
        end
        StPayload: begin
          if (accept) begin
            data_q <= cur_data;
            be_q   <= cur_be;
            full_q <= 1'b1;
            if (pkt_end) begin
              cont_q[grant_q] <= !cur_last;
              last_grant_q    <= grant_q;
              seq_q           <= seq_q + 8'd1;
              wcnt_q          <= '0;
              state_q         <= StIdle;
            end else begin
              wcnt_q <= wcnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_i                = data_q;
  assign i_valid               = be_q;
  assign periph_data_available = full_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: directed scenarios plus randomized
// traffic scored against a packet-level reference model.
module tb_usb_tx_arbiter;

  localparam int NP   = 4;
  localparam int MAXP = 4;
  localparam int MAXW = 64;

  logic              clk;
  logic              rst_l;
  logic [NP-1:0]     periph_valid;
  logic [NP*32-1:0]  periph_data;
  logic [NP*4-1:0]   periph_be;
  logic [NP-1:0]     periph_last;
  logic [NP-1:0]     periph_ready;
  logic [31:0]       data_i;
  logic [3:0]        i_valid;
  logic              periph_data_available;
  logic              read_periph_data;

  usb_tx_arbiter #(
    .NUM_PERIPH    (NP),
    .MAX_PKT_WORDS (MAXP)
  ) dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .periph_valid          (periph_valid),
    .periph_data           (periph_data),
    .periph_be             (periph_be),
    .periph_last           (periph_last),
    .periph_ready          (periph_ready),
    .data_i                (data_i),
    .i_valid               (i_valid),
    .periph_data_available (periph_data_available),
    .read_periph_data      (read_periph_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Source word lists
  logic [31:0] words    [NP][MAXW];
  logic [3:0]  bes      [NP][MAXW];
  logic        lasts    [NP][MAXW];
  logic        segstart [NP][MAXW];
  int          len      [NP];

  // Driver and model state
  int          drv_idx  [NP];
  logic [NP-1:0] acc;
  int          out_idx  [NP];
  int          m_last;
  logic [7:0]  m_seq;
  logic [NP-1:0] m_cont;
  int          m_cur;
  int          m_seg;
  bit          expect_hdr;
  int          n_consumed;
  logic [31:0] hdr_log[$];
  bit          hold;
  logic [31:0] held_data;
  logic [3:0]  held_be;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < NP; s++) len[s] = 0;
  endtask

  // Mark which words open a new packet on the output side.
  task automatic finalize();
    for (int s = 0; s < NP; s++) begin
      int c;
      c = 0;
      for (int k = 0; k < len[s]; k++) begin
        bit ss;
        ss = (k == 0) || lasts[s][k-1] || (c == MAXP);
        if (ss) c = 0;
        segstart[s][k] = ss;
        c++;
      end
    end
  endtask

  task automatic load_src(input int s, input int n);
    len[s] = n;
    for (int k = 0; k < n; k++) begin
      words[s][k] = $urandom;
      bes[s][k]   = 4'hF;
      lasts[s][k] = (k == n - 1);
    end
  endtask

  task automatic gen_random();
    for (int s = 0; s < NP; s++) begin
      len[s] = $urandom_range(0, 12);
      for (int k = 0; k < len[s]; k++) begin
        words[s][k] = $urandom;
        bes[s][k]   = 4'($urandom_range(1, 15));
        lasts[s][k] = ($urandom_range(0, 3) == 0) || (k == len[s] - 1);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l            = 1'b0;
    periph_valid     = '0;
    periph_data      = '0;
    periph_be        = '0;
    periph_last      = '0;
    read_periph_data = 1'b0;
    #1;
    chk("rst_avail", 32'(periph_data_available), 32'd0);
    chk("rst_data", data_i, 32'd0);
    chk("rst_be", 32'(i_valid), 32'd0);
    chk("rst_ready", 32'(periph_ready), 32'd0);
    for (int s = 0; s < NP; s++) begin
      drv_idx[s] = 0;
      out_idx[s] = 0;
    end
    acc        = '0;
    m_last     = NP - 1;
    m_seq      = 8'd0;
    m_cont     = '0;
    m_cur      = 0;
    m_seg      = 0;
    expect_hdr = 1'b1;
    n_consumed = 0;
    hold       = 1'b0;
    hdr_log.delete();
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
  endtask

  function automatic bit all_done();
    for (int s = 0; s < NP; s++) if (out_idx[s] < len[s]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: score one word leaving the output register.
  task automatic consume(input logic [31:0] d, input logic [3:0] be);
    n_consumed++;
    if (expect_hdr) begin
      int src;
      src = -1;
      for (int k = 1; k <= NP; k++) begin
        int c;
        c = (m_last + k) % NP;
        if (src < 0 && out_idx[c] < len[c]) src = c;
      end
      chk("word_expected", 32'(src >= 0), 32'd1);
      if (src >= 0) begin
        chk("hdr", d, {8'hA5, 8'(src), m_seq, 7'h00, m_cont[src]});
        chk("hdr_be", 32'(be), 32'hF);
        hdr_log.push_back(d);
        m_cur      = src;
        m_seg      = 0;
        expect_hdr = 1'b0;
      end
    end else begin
      int k;
      k = out_idx[m_cur];
      chk("pay_data", d, words[m_cur][k]);
      chk("pay_be", 32'(be), 32'(bes[m_cur][k]));
      out_idx[m_cur]++;
      m_seg++;
      if (lasts[m_cur][k] || m_seg == MAXP) begin
        m_cont[m_cur] = !lasts[m_cur][k];
        m_last        = m_cur;
        m_seq         = m_seq + 8'd1;
        expect_hdr    = 1'b1;
      end
    end
  endtask

  // Drive sources and the reader one cycle at a time until all words emerge.
  task automatic run_traffic(input int max_cycles, input int rd_pct, input int gap_pct,
                             input int stall_start, input int abort_after);
    int cyc;
    cyc = 0;
    while (!all_done() && cyc < max_cycles &&
           !(abort_after >= 0 && n_consumed >= abort_after)) begin
      bit rd;
      @(negedge clk);
      for (int s = 0; s < NP; s++) if (acc[s]) drv_idx[s]++;
      rd = ($urandom_range(0, 99) < rd_pct);
      if (cyc >= stall_start && cyc < stall_start + 5) rd = 1'b0;
      read_periph_data = rd;
      for (int s = 0; s < NP; s++) begin
        if (drv_idx[s] < len[s]) begin
          periph_data[s*32 +: 32] = words[s][drv_idx[s]];
          periph_be[s*4 +: 4]     = bes[s][drv_idx[s]];
          periph_last[s]          = lasts[s][drv_idx[s]];
          periph_valid[s]         = segstart[s][drv_idx[s]] ? 1'b1 :
                                    ($urandom_range(0, 99) >= gap_pct);
        end else begin
          periph_valid[s] = 1'b0;
          periph_last[s]  = 1'b0;
        end
      end
      #1;
      if (hold) begin
        chk("stall_avail", 32'(periph_data_available), 32'd1);
        chk("stall_data", data_i, held_data);
        chk("stall_be", 32'(i_valid), 32'(held_be));
      end
      chk("ready_onehot", 32'($onehot0(periph_ready)), 32'd1);
      if (periph_data_available && !rd) chk("ready_stall", 32'(periph_ready), 32'd0);
      acc       = periph_valid & periph_ready;
      hold      = periph_data_available && !rd;
      held_data = data_i;
      held_be   = i_valid;
      if (periph_data_available && rd) consume(data_i, i_valid);
      cyc++;
    end
    if (abort_after < 0) begin
      chk("completed", 32'(all_done()), 32'd1);
      @(negedge clk);
      periph_valid = '0;
      #1;
      chk("drained_avail", 32'(periph_data_available), 32'd0);
    end
  endtask

  initial begin
    rst_l            = 1'b0;
    periph_valid     = '0;
    periph_data      = '0;
    periph_be        = '0;
    periph_last      = '0;
    read_periph_data = 1'b0;

    // Single source, three words
    clear_srcs(); load_src(0, 3); finalize();
    do_reset();
    run_traffic(500, 100, 0, -10, -1);
    chk("t1_nhdr", 32'(hdr_log.size()), 32'd1);
    if (hdr_log.size() > 0) chk("t1_hdr0", hdr_log[0], 32'hA500_0000);

    // Two sources, no interleaving, seq advances
    clear_srcs(); load_src(1, 2); load_src(2, 2); finalize();
    do_reset();
    run_traffic(500, 100, 0, -10, -1);
    chk("t2_nhdr", 32'(hdr_log.size()), 32'd2);
    if (hdr_log.size() > 1) begin
      chk("t2_hdr0", hdr_log[0], 32'hA501_0000);
      chk("t2_hdr1", hdr_log[1], 32'hA502_0100);
    end

    // Reader stalls five cycles mid-packet
    clear_srcs(); load_src(0, 3); load_src(1, 3); finalize();
    do_reset();
    run_traffic(500, 100, 0, 4, -1);

    // Forced split at MAX_PKT_WORDS
    clear_srcs(); load_src(3, 6); finalize();
    do_reset();
    run_traffic(500, 100, 0, -10, -1);
    chk("t4_nhdr", 32'(hdr_log.size()), 32'd2);
    if (hdr_log.size() > 1) begin
      chk("t4_hdr0", hdr_log[0], 32'hA503_0000);
      chk("t4_hdr1", hdr_log[1], 32'hA503_0101);
    end

    // Reset mid-payload, then arbitration and seq restart
    clear_srcs(); load_src(2, 8); finalize();
    do_reset();
    run_traffic(500, 100, 0, -10, 3);
    clear_srcs(); load_src(0, 2); load_src(1, 2); finalize();
    do_reset();
    run_traffic(500, 100, 0, -10, -1);
    chk("t5_nhdr", 32'(hdr_log.size()), 32'd2);
    if (hdr_log.size() > 1) begin
      chk("t5_hdr0", hdr_log[0], 32'hA500_0000);
      chk("t5_hdr1", hdr_log[1], 32'hA501_0100);
    end

    // Randomized traffic, reader back-pressure and source gaps
    for (int it = 0; it < 8; it++) begin
      clear_srcs(); gen_random(); finalize();
      do_reset();
      run_traffic(3000, $urandom_range(30, 100), $urandom_range(0, 40), -10, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
